// File: rtl/track_tile_locator.sv
// track_tile_locator: maps each displayed pixel to the lane / map row of the
// ground tile under it. A per-line restoring divider produces the perspective
// reciprocal FOCAL/line_y once per line; the pixel path is then a 3-stage
// multiply/shift/constant-divide pipeline with no backpressure.
//
// Build option: define TRACK_ROW_WRAP_EN to wrap the row index modulo ROWS
// (map ring buffer). Without it, rows >= ROWS are reported out of range.
//
// Handshakes:
//   line_start is a one-cycle command accepted in any state. line_ready is a
//   level that stays high while the reciprocal for the latched line is valid.
//   pix_valid qualifies px/y_ball in the same cycle. out_valid qualifies
//   index_x/index_y/in_range exactly 3 cycles later. There is no ready path.
module track_tile_locator #(
    parameter int LANES   = 5,
    parameter int TILE_W  = 80,
    parameter int TILE_H  = 80,
    parameter int CX      = 180,
    parameter int FOCAL   = 480,
    parameter int PX_MIN  = 1,
    parameter int PX_MAX  = 399,
    parameter int PY_MIN  = 35,
    parameter int PY_MAX  = 479,
    parameter int DEPTH_K = 85,
    parameter int ROW_OFS = 80,
    parameter int ROWS    = 16,
    parameter int RB      = 16,
    localparam int QW     = RB + 10,
    localparam int IXW    = $clog2(LANES + 1),
    localparam int IYW    = $clog2(ROWS) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           line_start,
    input  logic [9:0]     line_y,
    output logic           line_ready,
    input  logic           pix_valid,
    input  logic [8:0]     px,
    input  logic [8:0]     y_ball,
    output logic           out_valid,
    output logic [IXW-1:0] index_x,
    output logic [IYW-1:0] index_y,
    output logic           in_range,
    output logic [1:0]     dbg_state
);

    localparam int CW  = $clog2(QW + 1);   // divider step counter width
    localparam int XW  = QW - RB + 12;     // world-coordinate width (signed)
    localparam int PW  = QW + 11;          // signed d * recip product width
    localparam int DPW = QW + 8;           // DEPTH_K * recip product width

    localparam logic [QW-1:0]        DIVIDEND = QW'(longint'(FOCAL) << RB);
    localparam logic [9:0]           PY_MIN_V = 10'(PY_MIN);
    localparam logic [9:0]           PY_MAX_V = 10'(PY_MAX);
    localparam logic [8:0]           PX_MIN_V = 9'(PX_MIN);
    localparam logic [8:0]           PX_MAX_V = 9'(PX_MAX);
    localparam logic [9:0]           CX_V     = 10'(CX);
    localparam logic signed [XW-1:0] CX_XW    = XW'(CX);
    localparam logic signed [XW-1:0] DK_XW    = XW'(DEPTH_K);
    localparam logic signed [XW-1:0] RO_XW    = XW'(ROW_OFS);
    localparam logic signed [XW-1:0] LANE_LIM = XW'(LANES * TILE_W);
    localparam logic [XW-1:0]        TW_XW    = XW'(TILE_W);
    localparam logic [XW-1:0]        TH_XW    = XW'(TILE_H);
    localparam logic [DPW-1:0]       DK_DPW   = DPW'(DEPTH_K);
`ifdef TRACK_ROW_WRAP_EN
    localparam logic [XW-1:0]        ROW_MASK = XW'(ROWS - 1);
`else
    localparam logic [XW-1:0]        ROWS_XW  = XW'(ROWS);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_READY = 2'd2
    } line_state_t;

    // ---------------- line state / divider ----------------
    line_state_t   state_q;
    logic [9:0]    line_y_q;
    logic          line_bad_q;
    logic          line_ready_q;
    logic [9:0]    rem_q;
    logic [QW-1:0] quo_q;
    logic [CW-1:0] cnt_q;
    logic [QW-1:0] recip_q;

    logic [10:0]   rem_sh;
    logic [9:0]    rem_d;
    logic [QW-1:0] quo_d;
    logic          line_bad_d;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits.
    always_comb begin
        rem_sh = {rem_q, quo_q[QW-1]};
        quo_d  = {quo_q[QW-2:0], 1'b0};
        rem_d  = rem_sh[9:0];
        if (rem_sh >= {1'b0, line_y_q}) begin
            rem_d    = 10'(rem_sh - {1'b0, line_y_q});
            quo_d[0] = 1'b1;
        end
        line_bad_d = (line_y < PY_MIN_V) || (line_y > PY_MAX_V);
    end

    // Line FSM: line_start always (re)loads; good lines divide for QW steps
    // and publish the quotient one cycle later, bad lines skip the divide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_y_q     <= '0;
            line_bad_q   <= 1'b0;
            line_ready_q <= 1'b0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
            recip_q      <= '0;
        end else if (line_start) begin
            state_q      <= S_DIV;
            line_y_q     <= line_y;
            line_bad_q   <= line_bad_d;
            line_ready_q <= 1'b0;
            rem_q        <= '0;
            quo_q        <= DIVIDEND;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_DIV: begin
                    if (line_bad_q) begin
                        state_q      <= S_READY;
                        line_ready_q <= 1'b1;
                    end else if (cnt_q == CW'(QW)) begin
                        state_q      <= S_READY;
                        line_ready_q <= 1'b1;
                        recip_q      <= quo_q;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_IDLE, S_READY: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign line_ready = line_ready_q;
    assign dbg_state  = state_q;

    // ---------------- pixel pipeline ----------------
    logic                 s1_v_q, s1_v_d;
    logic signed [9:0]    s1_dx_q, s1_dx_d;
    logic                 s1_pxok_q, s1_pxok_d;
    logic [QW-1:0]        s1_recip_q, s1_recip_d;
    logic                 s1_rdy_q, s1_rdy_d;
    logic                 s1_bad_q, s1_bad_d;
    logic [8:0]           s1_yb_q, s1_yb_d;

    logic                 s2_v_q, s2_v_d;
    logic signed [XW-1:0] s2_xw_q, s2_xw_d;
    logic signed [XW-1:0] s2_depth_q, s2_depth_d;
    logic                 s2_pxok_q, s2_pxok_d;
    logic                 s2_rdy_q, s2_rdy_d;
    logic                 s2_bad_q, s2_bad_d;
    logic [8:0]           s2_yb_q, s2_yb_d;

    logic                 out_valid_q, out_valid_d;
    logic [IXW-1:0]       index_x_q, index_x_d;
    logic [IYW-1:0]       index_y_q, index_y_d;
    logic                 in_range_q, in_range_d;

    logic signed [PW-1:0] prod;
    logic [DPW-1:0]       dprod;
    logic signed [XW-1:0] row_val;
    logic [XW-1:0]        row_idx;
    logic                 lane_ok;
    logic                 row_ok;

    // S1: centre px on the vanishing point and snapshot the line state, so a
    // same-cycle line_start only affects later pixels.
    always_comb begin
        s1_v_d     = pix_valid;
        s1_dx_d    = $signed({1'b0, px}) - $signed(CX_V);
        s1_pxok_d  = (px >= PX_MIN_V) && (px <= PX_MAX_V);
        s1_recip_d = recip_q;
        s1_rdy_d   = line_ready_q;
        s1_bad_d   = line_bad_q;
        s1_yb_d    = y_ball;
    end

    // S2: perspective-correct world x and depth; full-width products so
    // nothing is lost before the fixed-point shift.
    always_comb begin
        prod       = $signed({{(PW-10){s1_dx_q[9]}}, s1_dx_q})
                   * $signed({{(PW-QW){1'b0}}, s1_recip_q});
        dprod      = {{(DPW-QW){1'b0}}, s1_recip_q} * DK_DPW;
        s2_v_d     = s1_v_q;
        s2_xw_d    = XW'(prod >>> RB) + CX_XW;
        s2_depth_d = $signed(XW'(dprod >> RB)) - DK_XW;
        s2_pxok_d  = s1_pxok_q;
        s2_rdy_d   = s1_rdy_q;
        s2_bad_d   = s1_bad_q;
        s2_yb_d    = s1_yb_q;
    end

    // S3: constant divides to tile indices, validity and all-ones marking.
    always_comb begin
        lane_ok   = s2_v_q && s2_rdy_q && !s2_bad_q && s2_pxok_q
                 && !s2_xw_q[XW-1] && (s2_xw_q < LANE_LIM);
        index_x_d = lane_ok ? IXW'($unsigned(s2_xw_q) / TW_XW) : '1;
        row_val   = $signed({{(XW-9){1'b0}}, s2_yb_q}) + s2_depth_q - RO_XW;
        row_idx   = $unsigned(row_val) / TH_XW;
        row_ok    = s2_v_q && s2_rdy_q && !s2_bad_q && !row_val[XW-1];
`ifdef TRACK_ROW_WRAP_EN
        index_y_d = row_ok ? IYW'(row_idx & ROW_MASK) : '1;
`else
        row_ok    = row_ok && (row_idx < ROWS_XW);
        index_y_d = row_ok ? IYW'(row_idx) : '1;
`endif
        in_range_d  = lane_ok && row_ok;
        out_valid_d = s2_v_q;
    end

    // Pipeline registers; reset flushes every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_dx_q     <= '0;
            s1_pxok_q   <= 1'b0;
            s1_recip_q  <= '0;
            s1_rdy_q    <= 1'b0;
            s1_bad_q    <= 1'b0;
            s1_yb_q     <= '0;
            s2_v_q      <= 1'b0;
            s2_xw_q     <= '0;
            s2_depth_q  <= '0;
            s2_pxok_q   <= 1'b0;
            s2_rdy_q    <= 1'b0;
            s2_bad_q    <= 1'b0;
            s2_yb_q     <= '0;
            out_valid_q <= 1'b0;
            index_x_q   <= '1;
            index_y_q   <= '1;
            in_range_q  <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_dx_q     <= s1_dx_d;
            s1_pxok_q   <= s1_pxok_d;
            s1_recip_q  <= s1_recip_d;
            s1_rdy_q    <= s1_rdy_d;
            s1_bad_q    <= s1_bad_d;
            s1_yb_q     <= s1_yb_d;
            s2_v_q      <= s2_v_d;
            s2_xw_q     <= s2_xw_d;
            s2_depth_q  <= s2_depth_d;
            s2_pxok_q   <= s2_pxok_d;
            s2_rdy_q    <= s2_rdy_d;
            s2_bad_q    <= s2_bad_d;
            s2_yb_q     <= s2_yb_d;
            out_valid_q <= out_valid_d;
            index_x_q   <= index_x_d;
            index_y_q   <= index_y_d;
            in_range_q  <= in_range_d;
        end
    end

    assign out_valid = out_valid_q;
    assign index_x   = index_x_q;
    assign index_y   = index_y_q;
    assign in_range  = in_range_q;

endmodule

// File: tb/tb_track_tile_locator.sv
// Bench for track_tile_locator: a cycle-level reference model of the line
// state and the pixel arithmetic feeds an expected queue; a negedge monitor
// checks out_valid timing and the indices against it.
module tb_track_tile_locator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       line_start = 1'b0;
    logic [9:0] line_y = '0;
    logic       line_ready;
    logic       pix_valid = 1'b0;
    logic [8:0] px = '0;
    logic [8:0] y_ball = '0;
    logic       out_valid;
    logic [2:0] index_x;
    logic [4:0] index_y;
    logic       in_range;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // {due cycle[40:9], index_x[8:6], index_y[5:1], in_range[0]}
    logic [40:0] exp_q[$];

    // reference line state
    logic   m_ready = 1'b0;
    logic   m_bad   = 1'b0;
    int     m_cnt   = 0;
    longint m_recip = 0;
    longint m_pend  = 0;

    track_tile_locator dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .line_y     (line_y),
        .line_ready (line_ready),
        .pix_valid  (pix_valid),
        .px         (px),
        .y_ball     (y_ball),
        .out_valid  (out_valid),
        .index_x    (index_x),
        .index_y    (index_y),
        .in_range   (in_range),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // expected {index_x, index_y, in_range} from the current model line state
    function automatic logic [8:0] model_pix(input logic [8:0] p, input logic [8:0] yb);
        longint d, xw, dep, rv, row;
        logic lok, rok;
        logic [2:0] ix;
        logic [4:0] iy;
        d   = longint'(p) - 180;
        xw  = ((d * m_recip) >>> 16) + 180;
        dep = ((85 * m_recip) >> 16) - 85;
        rv  = longint'(yb) + dep - 80;
        row = (rv >= 0) ? rv / 80 : 0;
        lok = m_ready && !m_bad && (p >= 1) && (p <= 399) && (xw >= 0) && (xw < 400);
        rok = m_ready && !m_bad && (rv >= 0);
`ifndef TRACK_ROW_WRAP_EN
        rok = rok && (row < 16);
`endif
        ix = lok ? 3'(xw / 80) : 3'h7;
`ifdef TRACK_ROW_WRAP_EN
        iy = rok ? 5'(row % 16) : 5'h1f;
`else
        iy = rok ? 5'(row) : 5'h1f;
`endif
        return {ix, iy, lok && rok};
    endfunction

    // one clock of stimulus; the model advances as the DUT will at the next edge
    task automatic step(input logic ls, input logic [9:0] ly, input logic pv,
                        input logic [8:0] p, input logic [8:0] yb);
        logic [8:0] r;
        @(negedge clk);
        check_val("line_ready", line_ready, m_ready);
        line_start = ls;
        line_y     = ly;
        pix_valid  = pv;
        px         = p;
        y_ball     = yb;
        if (pv) begin
            r = model_pix(p, yb);
            exp_q.push_back({32'(cyc + 3), r});
        end
        if (ls) begin
            m_ready = 1'b0;
            m_bad   = (ly < 10'd35) || (ly > 10'd479);
            m_cnt   = m_bad ? 1 : 27;
            if (!m_bad) m_pend = (longint'(480) << 16) / longint'(ly);
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_ready = 1'b1;
                if (!m_bad) m_recip = m_pend;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic pix(input logic [8:0] p, input logic [8:0] yb);
        step(1'b0, '0, 1'b1, p, yb);
    endtask

    task automatic rand_pix(input int n);
        for (int i = 0; i < n; i++)
            pix(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"}, out_valid, 0);
        check_val({tag, "_index_x"}, index_x, 7);
        check_val({tag, "_index_y"}, index_y, 31);
        check_val({tag, "_in_range"}, in_range, 0);
        check_val({tag, "_line_ready"}, line_ready, 0);
        check_val({tag, "_state"}, dbg_state, 0);
    endtask

    // scoreboard: out_valid must appear exactly when the queue head is due
    always @(negedge clk) begin : sb
        logic        exp_v;
        logic [40:0] e;
        exp_v = (exp_q.size() > 0) && (exp_q[0][40:9] == 32'(cyc));
        check_val("out_valid", out_valid, exp_v);
        if (exp_v) begin
            e = exp_q.pop_front();
            check_val("index_x", index_x, e[8:6]);
            check_val("index_y", index_y, e[5:1]);
            check_val("in_range", in_range, e[0]);
        end
    end

    initial begin
        // reset
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // line 240: pixels during the divide, then the reference vectors
        step(1'b1, 10'd240, 1'b0, '0, '0);
        rand_pix(26);
        pix(9'd260, 9'd80);
        pix(9'd260, 9'd80);
        pix(9'd20, 9'd80);
        pix(9'd0, 9'd80);
        pix(9'd1, 9'd80);
        pix(9'd399, 9'd300);
        pix(9'd400, 9'd300);
        rand_pix(12);

        // same-cycle line_start + pixel uses the old (240) line state
        step(1'b1, 10'd120, 1'b1, 9'd200, 9'd0);
        rand_pix(26);
        pix(9'd200, 9'd0);
        rand_pix(8);

        // restart: second line_start 10 cycles into the first divide
        step(1'b1, 10'd240, 1'b0, '0, '0);
        rand_pix(9);
        step(1'b1, 10'd120, 1'b0, '0, '0);
        rand_pix(26);
        pix(9'd200, 9'd0);
        pix(9'd260, 9'd400);
        rand_pix(6);

        // bad lines: ready after one cycle, never in range
        step(1'b1, 10'd20, 1'b1, 9'd200, 9'd100);
        pix(9'd200, 9'd100);
        rand_pix(6);
        step(1'b1, 10'd500, 1'b0, '0, '0);
        rand_pix(4);
        step(1'b1, 10'd34, 1'b0, '0, '0);
        rand_pix(3);

        // line 35: deepest row, wrap / no-wrap boundary
        step(1'b1, 10'd35, 1'b0, '0, '0);
        idle(26);
        pix(9'd180, 9'd511);
        pix(9'd180, 9'd0);
        pix(9'd399, 9'd100);
        rand_pix(10);

        // line 479: shallowest good line
        step(1'b1, 10'd479, 1'b0, '0, '0);
        idle(26);
        pix(9'd180, 9'd0);
        pix(9'd180, 9'd74);
        pix(9'd180, 9'd75);
        rand_pix(10);

        // reset mid-divide with pixels streaming
        step(1'b1, 10'd240, 1'b0, '0, '0);
        rand_pix(8);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        m_ready = 1'b0;
        m_bad   = 1'b0;
        m_cnt   = 0;
        m_recip = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        line_start = 1'b0;
        pix_valid  = 1'b0;
        idle(6);
        pix(9'd260, 9'd80);
        idle(30);
        pix(9'd260, 9'd80);

        idle(6);
        check_val("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/track_tile_locator.md
# track_tile_locator

Pipelined perspective-to-track locator for the runner renderer. For every displayed pixel it returns the lane (column) and map row of the ground tile under that pixel, plus an in-range flag. It generalises the earlier fixed 5-lane, 80-pixel locator with parametrised geometry and a per-line sequential reciprocal divider, so no per-pixel division is needed. It sits between the VGA timing generator and the map/tile-colour lookup.

## Interface
- LANES, 5, number of track lanes
- TILE_W, 80, lane width in world units
- TILE_H, 80, row depth in world units
- CX, 180, vanishing-point x (screen px)
- FOCAL, 480, focal/baseline line (screen py)
- PX_MIN / PX_MAX, 1 / 399, accepted px window
- PY_MIN / PY_MAX, 35 / 479, accepted line window
- DEPTH_K, 85, depth scale
- ROW_OFS, 80, row origin offset subtracted from the scroll value
- ROWS, 16, map row ring size (power of two)
- RB, 16, reciprocal fraction bits; QW = RB+10 quotient width
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- line_start  in  1  one-cycle pulse; latch line_y, start the divider
- line_y  in  10  screen py of the upcoming line
- line_ready  out  1  reciprocal for current line valid
- pix_valid  in  1  pixel qualifier
- px  in  9  screen x
- y_ball  in  9  forward scroll distance
- out_valid  out  1  result qualifier
- index_x  out  IXW=$clog2(LANES+1)  lane; all ones = none
- index_y  out  IYW=$clog2(ROWS)+1  row; all ones = none
- in_range  out  1  both indices valid

## Operation
- Line FSM: IDLE -> DIV -> READY. line_start in any state loads line_y, clears line_ready, and goes to DIV (a line_start during DIV aborts and restarts).
- If line_y < PY_MIN or > PY_MAX: skip DIV, go straight to READY with line_bad=1. There is no divide by zero.
- DIV: restarting restoring divider, one quotient bit per cycle, QW cycles. recip = floor((FOCAL << RB) / line_y), unsigned QW bits. Then READY, line_bad=0.
- Pixel pipeline, one pixel per cycle, no backpressure:
  - S1: d = px - CX (signed, 10 b). Capture recip, line_ready, line_bad and y_ball.
  - S2: xw = ((d*recip) >>> RB) + CX (signed). depth = ((DEPTH_K*recip) >> RB) - DEPTH_K.
  - S3: lane = xw / TILE_W; row = (y_ball + depth - ROW_OFS) / TILE_H. Divisors are constants; products are full-width, with no truncation before the shift.
- The lane is valid iff line_ready, !line_bad, PX_MIN <= px <= PX_MAX, and 0 <= xw < LANES*TILE_W.
- The row is valid iff line_ready, !line_bad, and y_ball + depth - ROW_OFS >= 0, subject to the row-range rule in Configuration.
- An invalid index outputs all ones. in_range = lane valid AND row valid.

## Timing
- Reset: FSM IDLE, line_ready=0, recip=0, out_valid=0, index_x/index_y all ones, in_range=0.
- Pixel latency is exactly 3 cycles: out_valid(t+3) = pix_valid(t). All pixel outputs are registered.
- line_ready rises QW+1 = 27 cycles after the line_start edge for a good line. For a bad line it rises 1 cycle after.
- line_start and pix_valid in the same cycle: the pixel uses the pre-pulse line state. The new line state takes effect from the next cycle.
- A pixel presented while line_ready=0 still emits out_valid with in_range=0 and both indices all ones.
- Reset mid-divide: the divide is abandoned and line_ready stays 0 until the next full divide.

## Configuration
- TRACK_ROW_WRAP_EN defined: index_y = row mod ROWS (map ring buffer). A row is valid whenever non-negative.
- Not defined: a row >= ROWS is out of range, and index_y is all ones.

## Test plan
- line_y=240, wait line_ready (27 cycles); px=260, y_ball=80 -> recip=131072, index_x=4, index_y=1, in_range=1, 3 cycles later.
- Same line, px=20 -> xw=-140, index_x=7, in_range=0. px=0 -> outside PX window, in_range=0.
- line_y=20 -> line_ready after 1 cycle; any pixel -> in_range=0, both indices all ones.
- line_y=35, px=180, y_ball=511 -> recip=898779, depth=1080, row=18. With TRACK_ROW_WRAP_EN: index_y=2, in_range=1. Without it: index_y=31, in_range=0.
- line_start on line_y=240, second line_start 10 cycles later on line_y=120 -> line_ready 27 cycles after the second pulse, recip=262144. Pixels during the divide give in_range=0.
- Assert rst during DIV with pix_valid streaming -> all outputs at reset values immediately. Pipeline flushed, no stale out_valid after release.
